// File: rtl/mc_pkg.sv
// mc_pkg: shared state encodings, opcode/func constants and ALUop codes
// for the multi-cycle MIPS control unit.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_RD    = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WR    = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   function automatic logic op_ok(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
   endfunction

   function automatic logic func_ok(input logic [5:0] fn);
      return fn inside {FN_ADD, FN_ADDU, FN_AND, FN_OR, FN_SLT, FN_SLTU};
   endfunction

endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: combinational map from controller state (plus IR fields,
// zero flag, mem_ready and rst_n) to the datapath control strobes.
// Inputs : state_i, opcode_i, func_i, zero_i, mem_ready_i, rst_n_i
// Outputs: ALU/mux selects, memory/register strobes, PC enable, illegal pulse
module mc_out_decode
   import mc_pkg::*;
(
   input  logic [3:0] state_i,
   input  logic [5:0] opcode_i,
   input  logic [5:0] func_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   input  logic       rst_n_i,
   output logic [1:0] alu_op_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic       iord_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o,
   output logic       reg_write_o,
   output logic [1:0] pc_source_o,
   output logic       pc_en_o,
   output logic       illegal_o
);

   logic mem_write, ir_write, reg_write, pc_en, illegal;

   always_comb begin
      alu_op_o     = ALUOP_ADD;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      iord_o       = 1'b0;
      mem_read_o   = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      pc_source_o  = 2'b00;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      pc_en        = 1'b0;
      illegal      = 1'b0;
      case (state_i)
         S_FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            ir_write    = mem_ready_i;
            pc_en       = mem_ready_i;
         end
         S_DECODE: begin
            alu_src_b_o = 2'b11;
            illegal     = !op_ok(opcode_i);
         end
         S_MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
         end
         S_MEM_RD: begin
            mem_read_o = 1'b1;
            iord_o     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write    = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            iord_o    = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALUOP_FUNC;
         end
         S_R_WB: begin
            reg_dst_o = 1'b1;
            reg_write = func_ok(func_i);
            illegal   = !func_ok(func_i);
         end
         S_BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALUOP_SUB;
            pc_source_o = 2'b01;
            pc_en       = zero_i;
         end
         S_JUMP: begin
            pc_source_o = 2'b10;
            pc_en       = 1'b1;
         end
         S_ADDI_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
         end
         S_ADDI_WB: reg_write = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

   // Side-effecting strobes are suppressed during reset so a reset cycle
   // can never corrupt memory, registers or the PC.
   assign mem_write_o = mem_write & rst_n_i;
   assign ir_write_o  = ir_write & rst_n_i;
   assign reg_write_o = reg_write & rst_n_i;
   assign pc_en_o     = pc_en & rst_n_i;
   assign illegal_o   = illegal & rst_n_i;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS control unit sequencing
// fetch/decode/execute/memory/writeback and counting retired instructions.
// Inputs : clk, rst_n (sync, active-low), opcode, func, zero, mem_ready
// Outputs: ALU/mux selects, memory/register strobes, PC control,
//          illegal pulse, state (debug), instr_cnt
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [1:0]       ALUop,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic [1:0]       PCSource,
   output logic             pc_en,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_cnt
);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             retire;

   always_comb begin
      state_d = S_FETCH;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:    state_d = opcode == OP_RTYPE                  ? S_R_EXEC    :
                                (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR  :
                                opcode == OP_BEQ                    ? S_BRANCH    :
                                opcode == OP_J                      ? S_JUMP      :
                                opcode == OP_ADDI                   ? S_ADDI_EXEC : S_FETCH;
         S_MEM_ADDR:  state_d = opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:    state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB:    retire  = 1'b1;
         S_MEM_WR: begin
            state_d = mem_ready ? S_FETCH : S_MEM_WR;
            retire  = mem_ready;
         end
         S_R_EXEC:    state_d = S_R_WB;
         S_R_WB:      retire  = 1'b1;
         S_BRANCH:    retire  = 1'b1;
         S_JUMP:      retire  = 1'b1;
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_ADDI_WB:   retire  = 1'b1;
         default:     state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (retire) cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   mc_out_decode u_dec (
      .state_i      (state_q),
      .opcode_i     (opcode),
      .func_i       (func),
      .zero_i       (zero),
      .mem_ready_i  (mem_ready),
      .rst_n_i      (rst_n),
      .alu_op_o     (ALUop),
      .alu_src_a_o  (ALUSrcA),
      .alu_src_b_o  (ALUSrcB),
      .iord_o       (IorD),
      .mem_read_o   (MemRead),
      .mem_write_o  (MemWrite),
      .ir_write_o   (IRWrite),
      .reg_dst_o    (RegDst),
      .mem_to_reg_o (MemtoReg),
      .reg_write_o  (RegWrite),
      .pc_source_o  (PCSource),
      .pc_en_o      (pc_en),
      .illegal_o    (illegal)
   );

   assign state     = state_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl with a
// per-instruction behavioural model of the expected state walk and outputs.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic [1:0] aluop;
      logic       srca;
      logic [1:0] srcb;
      logic       iord, mr, mw, irw, regdst, m2r, rw;
      logic [1:0] pcs;
      logic       pc_en, ill;
   } ctl_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = 6'h00, func = 6'h00;
   logic        zero = 1'b0, mem_ready = 1'b1;
   logic [1:0]  ALUop, ALUSrcB, PCSource;
   logic        ALUSrcA, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, pc_en, illegal;
   logic [3:0]  state;
   logic [31:0] instr_cnt;
   logic [1:0]  ALUop2, ALUSrcB2, PCSource2;
   logic        ALUSrcA2, IorD2, MemRead2, MemWrite2, IRWrite2, RegDst2, MemtoReg2, RegWrite2, pc_en2, illegal2;
   logic [3:0]  state2;
   logic [1:0]  instr_cnt2;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
      .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .PCSource(PCSource), .pc_en(pc_en), .illegal(illegal),
      .state(state), .instr_cnt(instr_cnt)
   );

   // Narrow-counter instance exercises modulo wrap in a few retirements.
   multicycle_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
      .ALUop(ALUop2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .IorD(IorD2), .MemRead(MemRead2),
      .MemWrite(MemWrite2), .IRWrite(IRWrite2), .RegDst(RegDst2), .MemtoReg(MemtoReg2),
      .RegWrite(RegWrite2), .PCSource(PCSource2), .pc_en(pc_en2), .illegal(illegal2),
      .state(state2), .instr_cnt(instr_cnt2)
   );

   int          errors = 0, checks = 0, ncyc = 0;
   bit          chk_on = 1'b0;
   ctl_t        exp_ctl;
   int          exp_st;
   logic [31:0] exp_cnt = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Expected control word for one cycle, straight from the state action table.
   function automatic ctl_t expect_for(input int st, input logic [5:0] op, input logic [5:0] fn,
                                       input bit z, input bit mr, input bit rn);
      ctl_t c = '0;
      bit   fok = fn inside {6'h20, 6'h21, 6'h24, 6'h25, 6'h2a, 6'h2b};
      bit   ook = op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
      case (st)
         0:  begin c.mr = 1; c.srcb = 2'b01; c.irw = mr; c.pc_en = mr; end
         1:  begin c.srcb = 2'b11; c.ill = !ook; end
         2:  begin c.srca = 1; c.srcb = 2'b10; end
         3:  begin c.mr = 1; c.iord = 1; end
         4:  begin c.rw = 1; c.m2r = 1; end
         5:  begin c.mw = 1; c.iord = 1; end
         6:  begin c.srca = 1; c.aluop = 2'b10; end
         7:  begin c.regdst = 1; c.rw = fok; c.ill = !fok; end
         8:  begin c.srca = 1; c.aluop = 2'b01; c.pcs = 2'b01; c.pc_en = z; end
         9:  begin c.pcs = 2'b10; c.pc_en = 1; end
         10: begin c.srca = 1; c.srcb = 2'b10; end
         11: c.rw = 1;
         default: c.ill = 1;
      endcase
      if (!rn) begin
         c.mw = 0; c.rw = 0; c.irw = 0; c.pc_en = 0; c.ill = 0;
      end
      return c;
   endfunction

   ctl_t got_ctl;
   assign got_ctl = '{ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                      RegDst, MemtoReg, RegWrite, PCSource, pc_en, illegal};

   always @(negedge clk) begin
      if (chk_on) begin
         chk("ctl", 64'(got_ctl), 64'(exp_ctl));
         chk("state", 64'(state), 64'(exp_st));
         chk("cnt", 64'(instr_cnt), 64'(exp_cnt));
         chk("cnt2", 64'(instr_cnt2), 64'(exp_cnt[1:0]));
      end
   end

   // One clock cycle: drive inputs, publish expectations, advance the count model.
   task automatic step(input int st, input bit mr, input bit rn, input bit ret);
      rst_n     = rn;
      mem_ready = mr;
      exp_ctl   = expect_for(st, opcode, func, zero, mr, rn);
      exp_st    = st;
      chk_on    = 1'b1;
      ncyc++;
      @(posedge clk);
      #2;
      if (!rn) exp_cnt = 0;
      else if (ret) exp_cnt = exp_cnt + 1;
   endtask

   task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fwait, input int mwait, output int cyc);
      int start = ncyc;
      opcode = op;
      func   = fn;
      zero   = z;
      for (int i = 0; i < fwait; i++) step(0, 0, 1, 0);
      step(0, 1, 1, 0);
      step(1, 1, 1, 0);
      case (op)
         6'h00: begin step(6, 1, 1, 0); step(7, 1, 1, 1); end
         6'h23: begin
            step(2, 1, 1, 0);
            for (int i = 0; i < mwait; i++) step(3, 0, 1, 0);
            step(3, 1, 1, 0);
            step(4, 1, 1, 1);
         end
         6'h2b: begin
            step(2, 1, 1, 0);
            for (int i = 0; i < mwait; i++) step(5, 0, 1, 0);
            step(5, 1, 1, 1);
         end
         6'h04: step(8, 1, 1, 1);
         6'h02: step(9, 1, 1, 1);
         6'h08: begin step(10, 1, 1, 0); step(11, 1, 1, 1); end
         default: ;
      endcase
      cyc = ncyc - start;
   endtask

   initial begin
      int c, c2;
      logic [31:0] base;
      @(posedge clk);
      #2;
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      do_instr(6'h00, 6'h20, 0, 0, 0, c);
      chk("radd_cyc", 64'(c), 64'd4);
      chk("radd_cnt", 64'(instr_cnt), 64'd1);
      do_instr(6'h23, 6'h00, 0, 0, 2, c);
      chk("lw_cyc", 64'(c), 64'd7);
      base = instr_cnt;
      do_instr(6'h04, 6'h00, 1, 0, 0, c);
      chk("beq_cyc", 64'(c), 64'd3);
      do_instr(6'h04, 6'h00, 0, 0, 0, c);
      chk("beq_cnt", 64'(instr_cnt - base), 64'd2);
      do_instr(6'h2b, 6'h00, 0, 0, 0, c);
      do_instr(6'h02, 6'h00, 0, 0, 0, c2);
      chk("swj_cyc", 64'(c + c2), 64'd7);
      chk("swj_cnt", 64'(instr_cnt), 64'd6);
      do_instr(6'h08, 6'h00, 0, 1, 0, c);
      chk("addi_cyc", 64'(c), 64'd5);
      do_instr(6'h3f, 6'h00, 0, 0, 0, c);
      chk("ill_cyc", 64'(c), 64'd2);
      chk("ill_cnt", 64'(instr_cnt), 64'd7);
      do_instr(6'h00, 6'h00, 0, 0, 0, c);
      chk("rbad_cnt", 64'(instr_cnt), 64'd8);
      chk("wrap_cnt2", 64'(instr_cnt2), 64'd0);
      opcode = 6'h2b;
      step(0, 1, 1, 0);
      step(1, 1, 1, 0);
      step(2, 1, 1, 0);
      step(5, 1, 0, 0);
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_cnt", 64'(instr_cnt), 64'd0);
      do_instr(6'h00, 6'h25, 0, 0, 0, c);
      chk("post_rst_cnt", 64'(instr_cnt), 64'd1);
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
